// File: rtl/osnt_sume_regfile_pkg.sv
// Shared types and constants for the OSNT SUME IPIF register file.
package osnt_sume_regfile_pkg;

  localparam int REG_W = 32;
  localparam int BE_W  = REG_W / 8;
  localparam int LAT_W = 8;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_RDY,
    ST_WR_DONE,
    ST_RD_RDY,
    ST_RD_DONE
  } state_e;

  // Number of bits needed to hold 'value'. At exact powers of two this is one
  // more than $clog2, so the index window always reaches past the last
  // implemented register and stray addresses just above the map decode as
  // out-of-range instead of aliasing onto a real register.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/osnt_sume_ack_timer.sv
// Ack latency counter shared by the read and write RDY states. Loads 1 on
// start, counts while running and saturates at C_ACK_LATENCY.
module osnt_sume_ack_timer
  import osnt_sume_regfile_pkg::*;
#(
  parameter int C_ACK_LATENCY = 3
) (
  input  logic S_AXI_ACLK,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  input  logic run,
  output logic expire
);

  logic [LAT_W-1:0] cnt_q;

  // Latency counter: clear wins over start, start wins over counting.
  always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= LAT_W'(1);
    end else if (run && (cnt_q != LAT_W'(C_ACK_LATENCY))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = run && (cnt_q == LAT_W'(C_ACK_LATENCY));

endmodule

// File: rtl/osnt_sume_ipif_regfile.sv
// IPIF register-file slave: C_NUM_RW byte-writable control registers followed
// by C_NUM_RO read-only status registers, with programmable ack latency and
// error reporting on RO writes and out-of-range accesses.
// Optional clear-on-read strobes: define OSNT_SUME_REGFILE_CLR_ON_READ_EN.
module osnt_sume_ipif_regfile
  import osnt_sume_regfile_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_NUM_RW           = 4,
  parameter int          C_NUM_RO           = 4,
  parameter int          C_ACK_LATENCY      = 3,
  parameter logic [31:0] C_RW_RESET_VAL     = 32'h0
) (
  input  logic                                        S_AXI_ACLK,
  input  logic                                        S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]               Bus2IP_Addr,
  input  logic                                        Bus2IP_CS,
  input  logic                                        Bus2IP_RNW,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]               Bus2IP_Data,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]             Bus2IP_BE,
  output logic [C_S_AXI_DATA_WIDTH-1:0]               IP2Bus_Data,
  output logic                                        IP2Bus_RdAck,
  output logic                                        IP2Bus_WrAck,
  output logic                                        IP2Bus_Error,
  output logic [REG_W*C_NUM_RW-1:0]                   reg_out,
  output logic [C_NUM_RW-1:0]                         reg_wr_pulse,
  input  logic [REG_W*((C_NUM_RO > 0) ? C_NUM_RO : 1)-1:0] status_in,
  output logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)-1:0]  rd_clr_pulse
);

  localparam int IDX_W = clog2(C_NUM_RW + C_NUM_RO);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [REG_W-1:0] wdata_q;
  logic [BE_W-1:0]  be_q;
  logic [REG_W-1:0] rw_q [C_NUM_RW];

  int               idx_i;
  logic             wr_hit;
  logic             rd_hit;
  logic [REG_W-1:0] rd_word;
  logic             in_rdy;
  logic             timer_start;
  logic             timer_clear;
  logic             expire;
  logic             wr_commit;
  logic             rd_fire;
  logic             unused_addr;

  // Only the word-index field of the address is decoded.
  assign unused_addr = ^{Bus2IP_Addr[C_S_AXI_ADDR_WIDTH-1:IDX_W+2], Bus2IP_Addr[1:0]};

  assign idx_i       = int'(idx_q);
  assign wr_hit      = (idx_i < C_NUM_RW);
  assign in_rdy      = (state_q == ST_WR_RDY) || (state_q == ST_RD_RDY);
  assign timer_start = (state_q == ST_IDLE) && Bus2IP_CS;
  assign timer_clear = in_rdy && (!Bus2IP_CS || expire);
  assign wr_commit   = (state_q == ST_WR_RDY) && Bus2IP_CS && expire && wr_hit;
  assign rd_fire     = (state_q == ST_RD_RDY) && Bus2IP_CS && expire;

  osnt_sume_ack_timer #(
    .C_ACK_LATENCY (C_ACK_LATENCY)
  ) u_ack_timer (
    .S_AXI_ACLK (S_AXI_ACLK),
    .rst_n      (S_AXI_ARESETN),
    .start      (timer_start),
    .clear      (timer_clear),
    .run        (in_rdy),
    .expire     (expire)
  );

  // Read mux over RW registers then RO status words; misses return 0.
  always_comb begin
    rd_word = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < C_NUM_RW; i++) begin
      if (idx_i == i) begin
        rd_word = rw_q[i];
        rd_hit  = 1'b1;
      end
    end
    for (int j = 0; j < C_NUM_RO; j++) begin
      if (idx_i == C_NUM_RW + j) begin
        rd_word = status_in[REG_W*j +: REG_W];
        rd_hit  = 1'b1;
      end
    end
  end

  // Bus FSM: latch request, wait out the latency, pulse one ack, wait for CS low.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      IP2Bus_Data  <= '0;
      IP2Bus_RdAck <= 1'b0;
      IP2Bus_WrAck <= 1'b0;
      IP2Bus_Error <= 1'b0;
    end else begin
      IP2Bus_RdAck <= 1'b0;
      IP2Bus_WrAck <= 1'b0;
      IP2Bus_Error <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Bus2IP_CS) begin
            idx_q   <= Bus2IP_Addr[IDX_W+1:2];
            wdata_q <= Bus2IP_Data;
            be_q    <= Bus2IP_BE;
            state_q <= Bus2IP_RNW ? ST_RD_RDY : ST_WR_RDY;
          end
        end
        ST_WR_RDY: begin
          if (!Bus2IP_CS) begin
            state_q <= ST_IDLE;
          end else if (expire) begin
            IP2Bus_WrAck <= 1'b1;
            IP2Bus_Error <= wr_hit ? RESP_OK : RESP_ERR;
            state_q      <= ST_WR_DONE;
          end
        end
        ST_RD_RDY: begin
          if (!Bus2IP_CS) begin
            state_q <= ST_IDLE;
          end else if (expire) begin
            IP2Bus_RdAck <= 1'b1;
            IP2Bus_Error <= rd_hit ? RESP_OK : RESP_ERR;
            IP2Bus_Data  <= rd_word;
            state_q      <= ST_RD_DONE;
          end
        end
        ST_WR_DONE: begin
          if (!Bus2IP_CS) state_q <= ST_IDLE;
        end
        ST_RD_DONE: begin
          if (!Bus2IP_CS) begin
            state_q     <= ST_IDLE;
            IP2Bus_Data <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RW registers: byte-enabled commit on the WrAck edge; pulse fires even with BE=0.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < C_NUM_RW; i++) rw_q[i] <= C_RW_RESET_VAL;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      for (int i = 0; i < C_NUM_RW; i++) begin
        if (wr_commit && (idx_i == i)) begin
          reg_wr_pulse[i] <= 1'b1;
          for (int b = 0; b < BE_W; b++) begin
            if (be_q[b]) rw_q[i][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_RW; g++) begin : g_reg_out
    assign reg_out[REG_W*g +: REG_W] = rw_q[g];
  end

`ifdef OSNT_SUME_REGFILE_CLR_ON_READ_EN
  // Clear-on-read strobe for the RO register being acked this cycle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_clr_pulse <= '0;
    end else begin
      rd_clr_pulse <= '0;
      for (int j = 0; j < C_NUM_RO; j++) begin
        if (rd_fire && (idx_i == C_NUM_RW + j)) rd_clr_pulse[j] <= 1'b1;
      end
    end
  end
`else
  logic unused_rd_fire;
  assign unused_rd_fire = rd_fire;
  assign rd_clr_pulse   = '0;
`endif

endmodule

// File: tb/tb_osnt_sume_ipif_regfile.sv
// Directed bench: three register files sharing one bus, with ack latencies
// 3 (reset value A5A5_0000), 1 and 10 (reset value 0).
module tb_osnt_sume_ipif_regfile;

  localparam int ND = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     cs;
  logic                     rnw;
  logic [31:0]              addr;
  logic [31:0]              wdata;
  logic [3:0]               be;
  logic [127:0]             status;
  logic [ND-1:0]            rdack, wrack, err;
  logic [ND-1:0][31:0]      rdata;
  logic [ND-1:0][127:0]     regs;
  logic [ND-1:0][3:0]       pulse, clr;

  int n_checks = 0;
  int n_fail   = 0;

  int          ack_cyc   [ND];
  int          ack_cnt   [ND];
  int          stray_cnt [ND];
  int          pulse_cnt [ND];
  int          clr_cnt   [ND];
  logic        err_at    [ND];
  logic [31:0] data_at   [ND];
  logic [3:0]  pulse_at  [ND];
  logic [3:0]  clr_at    [ND];
  logic [31:0] exp_reg   [4];
  logic [3:0]  exp_clr0, exp_clr3;
  int          exp_clr_cnt;
  int          any_ack;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    osnt_sume_ipif_regfile #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (32),
      .C_NUM_RW           (4),
      .C_NUM_RO           (4),
      .C_ACK_LATENCY      ((g == 0) ? 3 : ((g == 1) ? 1 : 10)),
      .C_RW_RESET_VAL     ((g == 0) ? 32'hA5A5_0000 : 32'h0)
    ) u_dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .Bus2IP_Addr   (addr),
      .Bus2IP_CS     (cs),
      .Bus2IP_RNW    (rnw),
      .Bus2IP_Data   (wdata),
      .Bus2IP_BE     (be),
      .IP2Bus_Data   (rdata[g]),
      .IP2Bus_RdAck  (rdack[g]),
      .IP2Bus_WrAck  (wrack[g]),
      .IP2Bus_Error  (err[g]),
      .reg_out       (regs[g]),
      .reg_wr_pulse  (pulse[g]),
      .status_in     (status),
      .rd_clr_pulse  (clr[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) check(tag, regs[0][32*i +: 32], exp_reg[i]);
  endtask

  // One access held for 16 cycles (slowest ack at 11, plus 5 extra), then CS low.
  task automatic access(input logic r, input int idx, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    cs = 1'b1; rnw = r; addr = 32'(idx) << 2; wdata = d; be = b;
    for (int g = 0; g < ND; g++) begin
      ack_cyc[g] = -1; ack_cnt[g] = 0; stray_cnt[g] = 0; pulse_cnt[g] = 0; clr_cnt[g] = 0;
      err_at[g] = 1'bx; data_at[g] = 'x; pulse_at[g] = 'x; clr_at[g] = 'x;
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      for (int g = 0; g < ND; g++) begin
        if (r ? rdack[g] : wrack[g]) begin
          ack_cnt[g]++;
          if (ack_cyc[g] < 0) begin
            ack_cyc[g] = k; err_at[g] = err[g]; data_at[g] = rdata[g];
            pulse_at[g] = pulse[g]; clr_at[g] = clr[g];
          end
        end
        if (r ? wrack[g] : rdack[g]) stray_cnt[g]++;
        if (pulse[g] != 4'b0) pulse_cnt[g]++;
        if (clr[g] != 4'b0) clr_cnt[g]++;
      end
    end
    cs = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Watch n cycles and count any ack or write pulse on any instance.
  task automatic watch_quiet(input int n);
    any_ack = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if ((rdack != '0) || (wrack != '0)) any_ack++;
      for (int g = 0; g < ND; g++) if (pulse[g] != 4'b0) any_ack++;
    end
  endtask

  initial begin
`ifdef OSNT_SUME_REGFILE_CLR_ON_READ_EN
    exp_clr0 = 4'b0001; exp_clr3 = 4'b1000; exp_clr_cnt = 1;
`else
    exp_clr0 = 4'b0000; exp_clr3 = 4'b0000; exp_clr_cnt = 0;
`endif
    for (int i = 0; i < 4; i++) exp_reg[i] = 32'hA5A5_0000;
    rst_n = 1'b0; cs = 1'b0; rnw = 1'b0; addr = '0; wdata = '0; be = '0;
    status = {32'h0BAD_F00D, 32'h0000_0003, 32'h0000_0002, 32'hDEAD_BEEF};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdack", 128'(rdack), 128'(0));
    check("rst_wrack", 128'(wrack), 128'(0));
    check("rst_err",   128'(err),   128'(0));
    check("rst_rdata", 128'(rdata), 128'(0));
    check("rst_pulse", 128'(pulse), 128'(0));
    check("rst_clr",   128'(clr),   128'(0));
    check("rst_regs_d0", regs[0], {4{32'hA5A5_0000}});
    check("rst_regs_d1", regs[1], 128'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read idx 0: latency and single-ack behaviour on all three latencies
    access(1'b1, 0, 32'h0, 4'hF);
    check("rd0_lat_l3",  128'(ack_cyc[0]), 128'(4));
    check("rd0_lat_l1",  128'(ack_cyc[1]), 128'(2));
    check("rd0_lat_l10", 128'(ack_cyc[2]), 128'(11));
    check("rd0_cnt_l3",  128'(ack_cnt[0]), 128'(1));
    check("rd0_cnt_l1",  128'(ack_cnt[1]), 128'(1));
    check("rd0_cnt_l10", 128'(ack_cnt[2]), 128'(1));
    check("rd0_data",    128'(data_at[0]), 128'(32'hA5A5_0000));
    check("rd0_data_l1", 128'(data_at[1]), 128'(0));
    check("rd0_err",     128'(err_at[0]),  128'(0));
    check("rd0_stray",   128'(stray_cnt[0]), 128'(0));
    check("rd0_clear",   128'(rdata), 128'(0));

    // Clear idx 1, then partial write with BE=0101
    access(1'b0, 1, 32'h0, 4'hF);
    exp_reg[1] = 32'h0;
    check_regs("wr1_zero_regs");
    access(1'b0, 1, 32'h1122_3344, 4'b0101);
    exp_reg[1] = 32'h0022_0044;
    check_regs("wr1_be0101_regs");
    check("wr1_reg_l1",   128'(regs[1][63:32]), 128'(32'h0022_0044));
    check("wr1_lat",      128'(ack_cyc[0]),  128'(4));
    check("wr1_pulse_at", 128'(pulse_at[0]), 128'(4'b0010));
    check("wr1_pulse_cnt",128'(pulse_cnt[0]),128'(1));
    check("wr1_ack_cnt",  128'(ack_cnt[0]),  128'(1));
    check("wr1_err",      128'(err_at[0]),   128'(0));
    check("wr1_stray",    128'(stray_cnt[0]),128'(0));

    // Upper/odd byte lanes
    access(1'b0, 1, 32'hFFFF_FFFF, 4'b1010);
    exp_reg[1] = 32'hFF22_FF44;
    check_regs("wr1_be1010_regs");
    access(1'b1, 1, 32'h0, 4'hF);
    check("rd1_data", 128'(data_at[0]), 128'(32'hFF22_FF44));
    check("rd1_err",  128'(err_at[0]),  128'(0));

    // BE=0: nothing changes but the pulse still fires
    access(1'b0, 2, 32'hFFFF_FFFF, 4'b0000);
    check_regs("wr2_be0_regs");
    check("wr2_pulse_at", 128'(pulse_at[0]), 128'(4'b0100));
    check("wr2_err",      128'(err_at[0]),   128'(0));

    // Write to RO index 4
    access(1'b0, 4, 32'h5555_5555, 4'hF);
    check_regs("wro_regs");
    check("wro_err",       128'(err_at[0]),   128'(1));
    check("wro_lat",       128'(ack_cyc[0]),  128'(4));
    check("wro_pulse_cnt", 128'(pulse_cnt[0]),128'(0));

    // Read RO0 and RO3
    access(1'b1, 4, 32'h0, 4'hF);
    check("ro0_data",    128'(data_at[0]), 128'(32'hDEAD_BEEF));
    check("ro0_err",     128'(err_at[0]),  128'(0));
    check("ro0_clr_at",  128'(clr_at[0]),  128'(exp_clr0));
    check("ro0_clr_cnt", 128'(clr_cnt[0]), 128'(exp_clr_cnt));
    access(1'b1, 7, 32'h0, 4'hF);
    check("ro3_data",    128'(data_at[0]), 128'(32'h0BAD_F00D));
    check("ro3_clr_at",  128'(clr_at[0]),  128'(exp_clr3));

    // Out-of-range read, idx 15
    access(1'b1, 15, 32'h0, 4'hF);
    check("oor_data", 128'(data_at[0]), 128'(0));
    check("oor_err",  128'(err_at[0]),  128'(1));
    check("oor_lat",  128'(ack_cyc[0]), 128'(4));
    check("oor_clr_cnt", 128'(clr_cnt[0]), 128'(0));

    // Abort: CS dropped after one RDY cycle
    @(negedge clk);
    cs = 1'b1; rnw = 1'b0; addr = 32'h8; wdata = 32'hFFFF_FFFF; be = 4'hF;
    @(negedge clk);
    cs = 1'b0;
    watch_quiet(14);
    check("abort_acks", 128'(any_ack), 128'(0));
    check_regs("abort_regs");

    // Asynchronous reset during WR_RDY
    @(negedge clk);
    cs = 1'b1; rnw = 1'b0; addr = 32'hC; wdata = 32'h1234_5678; be = 4'hF;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_reg1",  128'(regs[0][63:32]), 128'(32'hA5A5_0000));
    check("arst_wrack", 128'(wrack), 128'(0));
    check("arst_err",   128'(err),   128'(0));
    check("arst_rdata", 128'(rdata), 128'(0));
    cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    watch_quiet(14);
    check("arst_acks", 128'(any_ack), 128'(0));
    for (int i = 0; i < 4; i++) exp_reg[i] = 32'hA5A5_0000;
    check_regs("arst_regs");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound in case the run stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
